// File: rtl/multicycle_controller_if.sv
// Shared memory-port handshake between the multicycle controller and memory.
// mem_req stays high until the cycle mem_ready=1; that cycle completes the access.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle FSM sequencing a MIPS subset over FETCH/DECODE/EXEC/MEM/WB,
// arbitrating one memory port and flagging illegal opcodes and memory timeouts.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic                    alu_zero,
  multicycle_controller_if.master mem,
  output logic                    ir_write,
  output logic                    mdr_write,
  output logic                    pc_write,
  output logic [1:0]              pc_src,
  output logic [3:0]              alu_op,
  output logic                    alu_src_imm,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic [2:0]              state,
  output logic                    illegal,
  output logic                    timeout,
  output logic [31:0]             instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_ADD, C_SUB, C_AND, C_ADDI, C_LW, C_SW, C_BEQ
  } class_e;

  localparam logic [5:0] OP_J = 6'h02;
  // A wait cycle that would bring the count to MEM_TIMEOUT halts instead.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  class_e      class_q, class_d;
  class_e      dec_class;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instr_count_q;
  logic        retire;

  function automatic class_e decode_class(input logic [5:0] op, input logic [5:0] fn);
    class_e c;
    c = C_NONE;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: c = C_ADD;
          6'h22:        c = C_SUB;
          6'h24:        c = C_AND;
          default:      c = C_NONE;
        endcase
      end
      6'h08:   c = C_ADDI;
      6'h23:   c = C_LW;
      6'h2B:   c = C_SW;
      6'h04:   c = C_BEQ;
      default: c = C_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_op_for(input class_e c);
    case (c)
      C_SUB:   return 4'b0001;
      C_AND:   return 4'b0010;
      C_BEQ:   return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    wait_d      = wait_q;
    retire      = 1'b0;
    dec_class   = decode_class(opcode, funct);
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    alu_op      = 4'b0000;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (opcode == OP_J) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          retire   = 1'b1;
          state_d  = S_FETCH;
          wait_d   = '0;
        end else if (dec_class == C_NONE) begin
          illegal = 1'b1;
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op      = alu_op_for(class_q);
        alu_src_imm = class_q inside {C_ADDI, C_LW, C_SW};
        case (class_q)
          C_LW, C_SW: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          C_BEQ: begin
            if (alu_zero) begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
            wait_d  = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_we  = (class_q == C_SW);
        alu_src_imm = 1'b1;
        if (mem.mem_ready) begin
          if (class_q == C_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
            wait_d  = '0;
          end else begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = class_q inside {C_ADD, C_SUB, C_AND};
        mem_to_reg = (class_q == C_LW);
        if (class_q != C_LW) begin
          alu_op      = alu_op_for(class_q);
          alu_src_imm = (class_q == C_ADDI);
        end
        retire  = 1'b1;
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_HALT: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      class_q       <= C_NONE;
      wait_q        <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      class_q       <= class_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_q + {31'd0, retire};
    end
  end

  assign state       = state_q;
  assign timeout     = (state_q == S_HALT);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: fixed instruction table, randomized instruction
// stream against a per-instruction phase model, and timeout/reset/wrap sequences.
module tb_multicycle_controller;
  localparam int TO = 15;
  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_ADDI = 4;
  localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_J = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        alu_zero = 1'b0;
  logic        ir_write, mdr_write, pc_write, alu_src_imm, reg_write, reg_dst;
  logic        mem_to_reg, illegal, timeout;
  logic [1:0]  pc_src;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_count;

  multicycle_controller_if mif();

  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem(mif), .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal),
    .timeout(timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic mem_req, mem_we, iord, ir_write, mdr_write, pc_write;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic alu_src_imm, reg_write, reg_dst, mem_to_reg, illegal, timeout;
  } outs_t;

  typedef struct {
    logic [5:0] op; logic [5:0] fn; logic z;
    int fw; int mw; int ret; int len; int pcw;
  } vec_t;

  logic [20:0] exp_q[$];
  logic        rdy_q[$];
  logic        zro_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = '0;
  vec_t        tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.st = state; o.mem_req = mif.mem_req; o.mem_we = mif.mem_we; o.iord = mif.iord;
    o.ir_write = ir_write; o.mdr_write = mdr_write; o.pc_write = pc_write;
    o.pc_src = pc_src; o.alu_op = alu_op; o.alu_src_imm = alu_src_imm;
    o.reg_write = reg_write; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
    o.illegal = illegal; o.timeout = timeout;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) return K_ADD;
      if (fn == 6'h22) return K_SUB;
      if (fn == 6'h24) return K_AND;
      return K_ILL;
    end
    if (op == 6'h08) return K_ADDI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h02) return K_J;
    return K_ILL;
  endfunction

  function automatic logic [3:0] alu_of(input int k);
    if (k == K_SUB) return 4'b0001;
    if (k == K_AND) return 4'b0010;
    if (k == K_BEQ) return 4'b1001;
    return 4'b0000;
  endfunction

  task automatic push(input outs_t o, input logic rdy, input logic z);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
    zro_q.push_back(z);
  endtask

  // One memory access: `waits` not-ready cycles, then completion, or HALT at the limit.
  task automatic access(input int waits, input outs_t busy, input outs_t done, output bit halted);
    outs_t h;
    halted = 1'b0;
    for (int i = 0; i < waits && i < TO; i++) push(busy, 1'b0, rbit());
    if (waits >= TO) begin
      halted = 1'b1;
      h = blank(3'd7);
      h.timeout = 1'b1;
      push(h, rbit(), rbit());
    end else begin
      push(done, 1'b1, rbit());
    end
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, output int ret);
    int k;
    outs_t o, d;
    bit h;
    k = classify(op, fn);
    ret = 0;
    o = blank(3'd1); o.mem_req = 1'b1;
    d = o; d.ir_write = 1'b1; d.pc_write = 1'b1;
    access(fw, o, d, h);
    if (h) return;
    o = blank(3'd2);
    if (k == K_J) begin o.pc_write = 1'b1; o.pc_src = 2'd2; end
    if (k == K_ILL) o.illegal = 1'b1;
    push(o, rbit(), rbit());
    if (k == K_J) begin ret = 1; return; end
    if (k == K_ILL) return;
    o = blank(3'd3);
    o.alu_op = alu_of(k);
    o.alu_src_imm = (k == K_ADDI || k == K_LW || k == K_SW);
    if (k == K_BEQ && z) begin o.pc_write = 1'b1; o.pc_src = 2'd1; end
    push(o, rbit(), z);
    if (k == K_BEQ) begin ret = 1; return; end
    if (k == K_LW || k == K_SW) begin
      o = blank(3'd4); o.mem_req = 1'b1; o.iord = 1'b1; o.alu_src_imm = 1'b1;
      o.mem_we = (k == K_SW);
      d = o;
      if (k == K_LW) d.mdr_write = 1'b1;
      access(mw, o, d, h);
      if (h) return;
      if (k == K_SW) begin ret = 1; return; end
    end
    o = blank(3'd5); o.reg_write = 1'b1;
    o.reg_dst = (k >= K_ADD && k <= K_AND);
    o.mem_to_reg = (k == K_LW);
    if (k != K_LW) begin o.alu_op = alu_of(k); o.alu_src_imm = (k == K_ADDI); end
    push(o, rbit(), rbit());
    ret = 1;
  endtask

  task automatic run_q(input int limit, output int len, output int pcw);
    outs_t e, a;
    logic r, z;
    int i;
    i = 0; len = 0; pcw = 0;
    while (exp_q.size() > 0 && i < limit) begin
      e = exp_q.pop_front(); r = rdy_q.pop_front(); z = zro_q.pop_front();
      @(negedge clk);
      mif.mem_ready = r;
      alu_zero = z;
      #1;
      a = sample();
      check($sformatf("cycle%0d st=%0d", i, e.st), 32'(a), 32'(e));
      if (a.st != 3'd1) len = i + 1;
      if (a.pc_write) pcw++;
      i++;
    end
  endtask

  task automatic check_count();
    @(posedge clk);
    #1;
    check("instr_count", instr_count, exp_cnt);
  endtask

  // Asserts reset (after the next negedge, or right now mid-cycle), then runs the IDLE cycle.
  task automatic do_reset(input bit now);
    int len, pcw;
    if (!now) begin @(negedge clk); #1; end
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_outs", 32'(sample()), 32'd0);
    check("rst_count", instr_count, 32'd0);
    exp_q.delete(); rdy_q.delete(); zro_q.delete();
    mif.mem_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_cnt = '0;
    push(blank(3'd0), rbit(), rbit());
    run_q(1, len, pcw);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    int len, pcw, ret, sel, fw, mw;
    logic [5:0] op, fn;
    logic z;
    outs_t h;

    tbl[0]  = '{6'h00, 6'h20, 1'b0, 0, 0, 1, 4, 1};
    tbl[1]  = '{6'h23, 6'h04, 1'b0, 0, 3, 1, 8, 1};
    tbl[2]  = '{6'h04, 6'h00, 1'b1, 0, 0, 1, 3, 2};
    tbl[3]  = '{6'h04, 6'h00, 1'b0, 0, 0, 1, 3, 1};
    tbl[4]  = '{6'h02, 6'h10, 1'b0, 0, 0, 1, 2, 2};
    tbl[5]  = '{6'h3F, 6'h00, 1'b0, 0, 0, 0, 2, 1};
    tbl[6]  = '{6'h00, 6'h21, 1'b1, 0, 0, 1, 4, 1};
    tbl[7]  = '{6'h00, 6'h22, 1'b0, 0, 0, 1, 4, 1};
    tbl[8]  = '{6'h00, 6'h24, 1'b1, 0, 0, 1, 4, 1};
    tbl[9]  = '{6'h08, 6'h05, 1'b0, 0, 0, 1, 4, 1};
    tbl[10] = '{6'h2B, 6'h08, 1'b1, 0, 0, 1, 4, 1};
    tbl[11] = '{6'h00, 6'h25, 1'b0, 0, 0, 0, 2, 1};
    tbl[12] = '{6'h2B, 6'h00, 1'b0, 14, 14, 1, 32, 1};
    tbl[13] = '{6'h23, 6'h00, 1'b0, 2, 0, 1, 7, 1};

    mif.mem_ready = 1'b0;
    do_reset(1'b0);

    for (int i = 0; i < 14; i++) begin
      set_ir(tbl[i].op, tbl[i].fn);
      build(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fw, tbl[i].mw, ret);
      run_q(1000, len, pcw);
      check($sformatf("tbl%0d len", i), 32'(len), 32'(tbl[i].len));
      check($sformatf("tbl%0d pc_write cycles", i), 32'(pcw), 32'(tbl[i].pcw));
      exp_cnt = exp_cnt + 32'(tbl[i].ret);
      check_count();
    end

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      fn = 6'($urandom_range(0, 63));
      case (sel)
        0: begin op = 6'h00; fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h21; end
        2: begin op = 6'h00; fn = 6'h22; end
        3: begin op = 6'h00; fn = 6'h24; end
        4: op = 6'h08;
        5: op = 6'h23;
        6: op = 6'h2B;
        7: op = 6'h04;
        8: op = 6'h02;
        default: op = 6'($urandom_range(0, 63));
      endcase
      z  = rbit();
      fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
      set_ir(op, fn);
      build(op, fn, z, fw, mw, ret);
      run_q(1000, len, pcw);
      exp_cnt = exp_cnt + 32'(ret);
      check_count();
    end

    h = blank(3'd7);
    h.timeout = 1'b1;

    // Fetch never answered: HALT after TO wait cycles, then stays there.
    do_reset(1'b0);
    set_ir(6'h00, 6'h20);
    build(6'h00, 6'h20, 1'b0, TO, 0, ret);
    for (int i = 0; i < 3; i++) push(h, rbit(), rbit());
    run_q(1000, len, pcw);
    check_count();

    // Data access never answered.
    do_reset(1'b0);
    set_ir(6'h23, 6'h04);
    build(6'h23, 6'h04, 1'b0, 0, TO, ret);
    for (int i = 0; i < 3; i++) push(h, rbit(), rbit());
    run_q(1000, len, pcw);
    check_count();

    // Reset dropped in the middle of a stalled sw data write.
    do_reset(1'b0);
    set_ir(6'h2B, 6'h00);
    build(6'h2B, 6'h00, 1'b0, 0, TO, ret);
    run_q(5, len, pcw);
    do_reset(1'b1);

    // Counter wrap from all-ones.
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    set_ir(6'h02, 6'h10);
    build(6'h02, 6'h10, 1'b0, 0, 0, ret);
    run_q(1000, len, pcw);
    exp_cnt = exp_cnt + 32'(ret);
    check_count();
    set_ir(6'h00, 6'h20);
    build(6'h00, 6'h20, 1'b0, 0, 0, ret);
    run_q(1000, len, pcw);
    exp_cnt = exp_cnt + 32'(ret);
    check_count();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control FSM that sequences the single-cycle-decoded MIPS subset (add, addu, sub, and, addi, lw, sw, beq, j) over FETCH/DECODE/EXEC/MEM/WB.
- Arbitrates one shared memory port between instruction fetch and data access.
- Drives all datapath strobes, including PC, IR, MDR, register file and ALU.
- Detects illegal instructions and memory-handshake timeouts.

Parameters:
- MEM_TIMEOUT, 15: max cycles mem_req may wait for mem_ready before HALT; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until next IR write
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepts/completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write enable, qualified by mem_req
- iord  out  1  0 = PC address, 1 = ALU-result address
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load MDR from memory read data
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target {PC[31:28], adr, 2'b00}
- alu_op  out  4  0000 add, 0001 sub, 0010 and, 1001 compare-sub
- alu_src_imm  out  1  ALU B = sign-extended imm
- reg_write  out  1  register-file write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  write-back data from MDR
- state  out  3  current state encoding
- illegal  out  1  one-cycle pulse on an undecodable instruction
- timeout  out  1  sticky; set on entry to HALT
- instr_count  out  32  retired-instruction counter

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7.
- Outputs are combinational from state, the latched class, mem_ready and alu_zero. Every output is 0 when not listed as asserted.
- Reset (rst_n=0, asynchronous, any time including mid-memory-wait): state=IDLE, class=0, wait counter=0, timeout=0, instr_count=0. All outputs 0 immediately; mem_req drops in the same cycle.
- IDLE: no outputs asserted; go to FETCH on the next edge unconditionally.
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - While mem_ready=0, stay.
  - In the mem_ready=1 cycle: ir_write=1, pc_write=1, pc_src=0; go to DECODE. Latency is one cycle minimum.
- DECODE: one cycle; latch class from opcode/funct.
  - R-type funct 0x20/0x21/0x22/0x24, addi 0x08, lw 0x23, sw 0x2B, beq 0x04: go to EXEC.
  - j 0x02: pc_write=1, pc_src=2 in this cycle; go to FETCH; retires.
  - Any other opcode, or opcode 0 with any other funct: illegal=1 for this cycle; go to FETCH; does not retire.
- EXEC: one cycle.
  - alu_op: add/addu/addi/lw/sw=0000, sub=0001, and=0010, beq=1001.
  - alu_src_imm=1 for addi/lw/sw; 0 for R-type and beq.
  - R-type/addi go to WB. lw/sw go to MEM.
  - beq: if alu_zero=1, pc_write=1 and pc_src=1; go to FETCH in either case; retires.
- MEM:
  - mem_req=1, iord=1, alu_op=0000, alu_src_imm=1 (address held); mem_we=1 for sw.
  - Stay while mem_ready=0.
  - On mem_ready=1: sw goes to FETCH (retires); lw asserts mdr_write=1 and goes to WB.
- WB: one cycle.
  - reg_write=1.
  - reg_dst=1 for R-type, 0 for addi/lw.
  - mem_to_reg=1 for lw only.
  - R-type/addi hold alu_op/alu_src_imm as in EXEC.
  - Go to FETCH; retires.
- Retire: instr_count increments by 1 on the edge that leaves a retiring state. Wraps 0xFFFFFFFF to 0.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle mem_req=1 and mem_ready=0.
  - If it equals MEM_TIMEOUT while mem_ready=0: go to HALT, timeout=1.
  - mem_ready=1 in the same cycle the limit is reached wins; the access completes normally.
- HALT: all outputs 0 except state=7 and timeout=1; leaves only on reset.
- Simultaneous events:
  - alu_zero is ignored outside EXEC.
  - mem_ready is ignored outside FETCH/MEM; it produces no strobes.
- Cycle counts with mem_ready tied 1: R/addi 4, lw 5, sw 4, beq 3, j 2, illegal 2.

Test Plan:
- Reset released, mem_ready=1, IR=add $3,$1,$2 (0x00221820) -> state 0→1→2→3→5→1. WB has reg_write=1, reg_dst=1, alu_op=0000. instr_count=1.
- lw (0x8C220004) with mem_ready low for 3 MEM cycles -> mem_req=1, iord=1 held 4 cycles. mdr_write=1 only in the ready cycle. WB has mem_to_reg=1, reg_dst=0.
- beq with alu_zero=1, then beq with alu_zero=0 -> pc_write=1, pc_src=1 in EXEC for the first only. Both retire; instr_count +2.
- j (0x08000010) -> pc_write=1, pc_src=2 in DECODE; next state FETCH after 2 total cycles. Opcode 0x3F -> illegal pulse of 1 cycle, instr_count unchanged.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> state=7, timeout=1 after 15 wait cycles, mem_req=0. rst_n pulse -> IDLE, timeout=0, instr_count=0.
- rst_n asserted mid-MEM of sw -> mem_req and mem_we drop to 0 without a clock edge. Preload instr_count 0xFFFFFFFF via retires (force) -> next retire gives 0.
